alu_shift_sequencer: RTL and testbench
======================================

# alu_shift_sequencer

Sequencer for the ALU shifter core (`alu_shifter_core`). It accepts one Z80 shift/rotate command and computes the result by driving the core's `db`, `shift_enable`, `shift_right`, `shift_in` and `oe` inputs over one or more passes. It captures `out` and `cy_out`, then reports the result, the updated accumulator and the S/Z/P/C flags. It sits between instruction decode and the shifter core, and serialises CB-prefix shifts and the 4-pass RLD/RRD nibble rotates.

## Interface
Parameters: none.
- `clk`  in  1  system clock, rising edge
- `nreset`  in  1  reset, asynchronous, active-low
- `start`  in  1  command strobe; sampled only in IDLE
- `op`  in  4  command, `alu_shift_pkg::shift_op_t`
- `operand`  in  8  value to shift (register, or (HL) for RLD/RRD)
- `acc_in`  in  8  accumulator; used only by RLD/RRD
- `cy_in`  in  1  current carry flag
- `busy`  out  1  high from the cycle after `start` is accepted until DONE exits
- `done`  out  1  one-cycle pulse; results are valid
- `result`  out  8  shifted value (new (HL) for RLD/RRD)
- `acc_out`  out  8  new accumulator; equals `acc_in` for non-nibble ops
- `cf, sf, zf, pf`  out  1 each  carry, sign, zero, even-parity flags
- `sh_db`  out  8  to core `db`
- `sh_enable, sh_right, sh_in, sh_oe`  out  1 each  to core `shift_enable`, `shift_right`, `shift_in`, `oe`
- `sh_out`  in  8  from core `out`
- `sh_cy`  in  1  from core `cy_out`

## Operation
Core contract, combinational:
- Enable and right: `out={shift_in,db[7:1]}`, `cy_out=db[0]`.
- Enable and left: `out={db[6:0],shift_in}`, `cy_out=db[7]`.
- Enable low: `out=db`.

FSM states: IDLE, SHIFT, DONE.
- IDLE, `start`=1: latch `op`, `operand`, `acc_in`, `cy_in`. Set pass counter to 0 for single ops or 3 for RLD/RRD. Go to SHIFT.
- SHIFT: drive `sh_db`=working register, `sh_oe`=1, `sh_enable`=1.
  - At the clock edge: working register <= `sh_out`.
  - If counter=0, go to DONE; otherwise decrement.
- DONE: `done`=1, outputs updated. Go to IDLE unconditionally.

Single-pass ops (direction, `sh_in`):
- RLC: left, `operand[7]`
- RRC: right, `operand[0]`
- RL: left, `cy_in`
- RR: right, `cy_in`
- SLA: left, 0
- SRA: right, `operand[7]`
- SLL: left, 1
- SRL: right, 0
- Flags: `cf`=captured `sh_cy`; S/Z/P taken from `result`.

RLD (4 passes, left):
- `acc_lo` is a 4-bit shift register initialised to `acc_in[3:0]`.
- Each pass: `sh_in`=`acc_lo[3]`, then `acc_lo <= {acc_lo[2:0], sh_cy}`.
- Final: `result={operand[3:0],acc_in[3:0]}`, `acc_out={acc_in[7:4],operand[7:4]}`.

RRD (4 passes, right):
- Each pass: `sh_in`=`acc_lo[0]`, then `acc_lo <= {sh_cy, acc_lo[3:1]}`.
- Final: `result={acc_in[3:0],operand[7:4]}`, `acc_out={acc_in[7:4],operand[3:0]}`.
- RLD/RRD flags: `cf`=`cy_in` (unchanged); S/Z/P taken from `acc_out`.

Op codes 10–15: one pass with `sh_enable`=0. `result`=`operand`, `cf`=`cy_in`.

Boundary conditions:
- `start` outside IDLE is ignored; there is no queueing.
- `done` and a new `start` can never coincide. `start` in the DONE cycle is ignored; the next is accepted in IDLE.
- `nreset` low at any time forces IDLE immediately and clears all registers, including mid RLD/RRD.
- Outputs hold their last values until the next DONE.

## Timing
- Reset value: every output is 0, including `sh_oe`, `sh_db` and `pf`.
- `start` sampled at edge N:
  - single op: SHIFT in cycle N+1, `done` in cycle N+2;
  - RLD/RRD: SHIFT in cycles N+1..N+4, `done` in cycle N+5.
- `busy`=1 in SHIFT and DONE.
- The `sh_*` outputs are registered or decoded from state only. `sh_oe`=0 outside SHIFT; `sh_db`=0 in IDLE.
- `sh_out` and `sh_cy` are sampled only at the end of SHIFT cycles.
- Throughput: one single op per 3 cycles.

## Structure
- `alu_shift_pkg`:
  - `shift_op_t` enum: RLC=0, RRC, RL, RR, SLA, SRA, SLL, SRL, RLD=8, RRD=9
  - `seq_state_t` enum: IDLE, SHIFT, DONE
  - constant `NIBBLE_PASSES`=4
- Sub-module `alu_flag_gen`: combinational 8-bit input to S/Z/P.
- `alu_shifter_core` stays external; the bench connects it to the `sh_*` ports.

## Test plan
- RLC, `operand`=0x81 -> `result`=0x03, `cf`=1, `sf`=0, `zf`=0, `pf`=1; `done` in cycle N+2.
- RR, `operand`=0x01, `cy_in`=0 -> `result`=0x00, `cf`=1, `zf`=1, `pf`=1.
- SRA 0x80 -> 0xC0, `cf`=0, `sf`=1, `pf`=1. SLL 0x00 -> 0x01, `pf`=0.
- RLD, `acc_in`=0x12, `operand`=0x34, `cy_in`=1 -> `result`=0x42, `acc_out`=0x13, `cf`=1; exactly 4 SHIFT cycles, `done` in cycle N+5.
- RRD, `acc_in`=0x12, `operand`=0x34 -> `result`=0x23, `acc_out`=0x14. Pulse `start` during the 2nd pass -> ignored; results unchanged.
- Pull `nreset` low in the 3rd RLD pass -> all outputs 0 asynchronously. A fresh RLC after release completes correctly.

Source files
------------

// File: rtl/alu_shift_pkg.sv
// ============================================================================
// Module  : alu_shift_pkg
// Purpose : Shared command codes, sequencer states and constants for the
//           ALU shift sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_shift_pkg;

    typedef enum logic [3:0] {
        RLC = 4'd0,
        RRC = 4'd1,
        RL  = 4'd2,
        RR  = 4'd3,
        SLA = 4'd4,
        SRA = 4'd5,
        SLL = 4'd6,
        SRL = 4'd7,
        RLD = 4'd8,
        RRD = 4'd9
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam int NIBBLE_PASSES = 4;

endpackage

`default_nettype wire

// File: rtl/alu_flag_gen.sv
// ============================================================================
// Module  : alu_flag_gen
// Purpose : Sign, zero and even-parity flags of an 8-bit value.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_flag_gen (
    input  logic [7:0] value,
    output logic       sf,
    output logic       zf,
    output logic       pf
);

    assign sf = value[7];
    assign zf = (value == 8'h00);
    assign pf = ~^value;

endmodule

`default_nettype wire

// File: rtl/alu_shift_sequencer.sv
// ============================================================================
// Module  : alu_shift_sequencer
// Purpose : Drives the external shifter core over one or four passes to
//           execute Z80 shift/rotate and RLD/RRD commands.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_shift_sequencer
    import alu_shift_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [3:0] op,
    input  logic [7:0] operand,
    input  logic [7:0] acc_in,
    input  logic       cy_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [7:0] acc_out,
    output logic       cf,
    output logic       sf,
    output logic       zf,
    output logic       pf,
    output logic [7:0] sh_db,
    output logic       sh_enable,
    output logic       sh_right,
    output logic       sh_in,
    output logic       sh_oe,
    input  logic [7:0] sh_out,
    input  logic       sh_cy
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;
    localparam logic [1:0] C_NIB_CNT = 2'(NIBBLE_PASSES - 1);

    logic [1:0] r_state;
    logic [3:0] r_op;
    logic [7:0] r_acc;
    logic       r_cy;
    logic [7:0] r_work;
    logic [3:0] r_acc_lo;
    logic [1:0] r_cnt;

    logic       w_in_shift;
    logic       w_nibble;
    logic       w_bypass;
    logic       w_right;
    logic       w_shin;
    logic [3:0] w_acc_lo_next;
    logic [7:0] w_acc_final;
    logic [7:0] w_flag_src;
    logic       w_cf;
    logic       w_sf;
    logic       w_zf;
    logic       w_pf;

    assign w_in_shift = (r_state == ST_SHIFT);
    assign w_nibble   = (r_op == RLD) || (r_op == RRD);
    assign w_bypass   = (r_op >= 4'd10);

    // Single-pass ops see the untouched operand in r_work, so its end bits
    // double as the rotate/sign fill source.
    always_comb begin
        w_right = 1'b0;
        w_shin  = 1'b0;
        case (r_op)
            RLC: w_shin = r_work[7];
            RRC: begin w_right = 1'b1; w_shin = r_work[0]; end
            RL:  w_shin = r_cy;
            RR:  begin w_right = 1'b1; w_shin = r_cy; end
            SLA: w_shin = 1'b0;
            SRA: begin w_right = 1'b1; w_shin = r_work[7]; end
            SLL: w_shin = 1'b1;
            SRL: w_right = 1'b1;
            RLD: w_shin = r_acc_lo[3];
            RRD: begin w_right = 1'b1; w_shin = r_acc_lo[0]; end
            default: begin w_right = 1'b0; w_shin = 1'b0; end
        endcase
    end

    assign sh_oe     = w_in_shift;
    assign sh_enable = w_in_shift & ~w_bypass;
    assign sh_right  = w_in_shift & w_right;
    assign sh_in     = w_in_shift & w_shin;
    assign sh_db     = w_in_shift ? r_work : 8'h00;

    // The accumulator nibble circulates through the core's carry path.
    assign w_acc_lo_next = (r_op == RRD) ? {sh_cy, r_acc_lo[3:1]}
                                         : {r_acc_lo[2:0], sh_cy};
    assign w_acc_final   = w_nibble ? {r_acc[7:4], w_acc_lo_next} : r_acc;
    assign w_flag_src    = w_nibble ? w_acc_final : sh_out;
    assign w_cf          = (w_nibble || w_bypass) ? r_cy : sh_cy;

    alu_flag_gen u_flag_gen (
        .value (w_flag_src),
        .sf    (w_sf),
        .zf    (w_zf),
        .pf    (w_pf)
    );

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state  <= ST_IDLE;
            r_op     <= 4'h0;
            r_acc    <= 8'h00;
            r_cy     <= 1'b0;
            r_work   <= 8'h00;
            r_acc_lo <= 4'h0;
            r_cnt    <= 2'd0;
            result   <= 8'h00;
            acc_out  <= 8'h00;
            cf       <= 1'b0;
            sf       <= 1'b0;
            zf       <= 1'b0;
            pf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_acc    <= acc_in;
                        r_cy     <= cy_in;
                        r_work   <= operand;
                        r_acc_lo <= acc_in[3:0];
                        r_cnt    <= ((op == RLD) || (op == RRD)) ? C_NIB_CNT : 2'd0;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_work   <= sh_out;
                    r_acc_lo <= w_acc_lo_next;
                    if (r_cnt == 2'd0) begin
                        r_state <= ST_DONE;
                        result  <= sh_out;
                        acc_out <= w_acc_final;
                        cf      <= w_cf;
                        sf      <= w_sf;
                        zf      <= w_zf;
                        pf      <= w_pf;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_shift_sequencer.sv
// ============================================================================
// Module  : tb_alu_shift_sequencer
// Purpose : Directed scoreboard bench for alu_shift_sequencer with a
//           behavioural shifter core attached to the sh_* ports.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_shift_sequencer;

    logic       clk;
    logic       nreset;
    logic       start;
    logic [3:0] op;
    logic [7:0] operand;
    logic [7:0] acc_in;
    logic       cy_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] acc_out;
    logic       cf, sf, zf, pf;
    logic [7:0] sh_db;
    logic       sh_enable, sh_right, sh_in, sh_oe;
    logic [7:0] sh_out;
    logic       sh_cy;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] acc;
        logic       cf;
        logic       sf;
        logic       zf;
        logic       pf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_shift_sequencer dut (
        .clk       (clk),
        .nreset    (nreset),
        .start     (start),
        .op        (op),
        .operand   (operand),
        .acc_in    (acc_in),
        .cy_in     (cy_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .acc_out   (acc_out),
        .cf        (cf),
        .sf        (sf),
        .zf        (zf),
        .pf        (pf),
        .sh_db     (sh_db),
        .sh_enable (sh_enable),
        .sh_right  (sh_right),
        .sh_in     (sh_in),
        .sh_oe     (sh_oe),
        .sh_out    (sh_out),
        .sh_cy     (sh_cy)
    );

    // Behavioural stand-in for the external shifter core.
    always_comb begin
        sh_out = sh_db;
        sh_cy  = 1'b0;
        if (sh_enable) begin
            if (sh_right) begin
                sh_out = {sh_in, sh_db[7:1]};
                sh_cy  = sh_db[0];
            end else begin
                sh_out = {sh_db[6:0], sh_in};
                sh_cy  = sh_db[7];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model(input logic [3:0] o, input logic [7:0] v,
                                   input logic [7:0] a, input logic c);
        exp_t       e;
        logic [7:0] src;
        e.acc = a;
        e.cf  = c;
        case (o)
            4'd0: begin e.res = {v[6:0], v[7]};  e.cf = v[7]; end
            4'd1: begin e.res = {v[0], v[7:1]};  e.cf = v[0]; end
            4'd2: begin e.res = {v[6:0], c};     e.cf = v[7]; end
            4'd3: begin e.res = {c, v[7:1]};     e.cf = v[0]; end
            4'd4: begin e.res = {v[6:0], 1'b0};  e.cf = v[7]; end
            4'd5: begin e.res = {v[7], v[7:1]};  e.cf = v[0]; end
            4'd6: begin e.res = {v[6:0], 1'b1};  e.cf = v[7]; end
            4'd7: begin e.res = {1'b0, v[7:1]};  e.cf = v[0]; end
            4'd8: begin e.res = {v[3:0], a[3:0]}; e.acc = {a[7:4], v[7:4]}; end
            4'd9: begin e.res = {a[3:0], v[7:4]}; e.acc = {a[7:4], v[3:0]}; end
            default: e.res = v;
        endcase
        src  = (o == 4'd8 || o == 4'd9) ? e.acc : e.res;
        e.sf = src[7];
        e.zf = (src == 8'h00);
        e.pf = ($countones(src) % 2) == 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // glitch_k: cycle (1 = first after acceptance) in which a stray start is driven.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] v,
                          input logic [7:0] a, input logic c,
                          input int exp_lat, input int glitch_k);
        int   k;
        int   shifts;
        logic got;
        exp_t e;
        @(negedge clk);
        op = o; operand = v; acc_in = a; cy_in = c; start = 1'b1;
        sb.push_back(model(o, v, a, c));
        @(negedge clk);
        start = 1'b0;
        k = 1; shifts = 0; got = 1'b0;
        while (k <= 12 && !got) begin
            if (sh_oe) shifts++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (k == glitch_k) begin
                    start = 1'b1; op = 4'd0; operand = 8'hFF; acc_in = 8'h00; cy_in = ~c;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(k), 64'(exp_lat));
        check({tag, "_passes"}, 64'(shifts), 64'(exp_lat - 1));
        e = sb.pop_front();
        check({tag, "_result"}, 64'(result), 64'(e.res));
        check({tag, "_acc_out"}, 64'(acc_out), 64'(e.acc));
        check({tag, "_flags_cszp"}, 64'({cf, sf, zf, pf}), 64'({e.cf, e.sf, e.zf, e.pf}));
        if (k == glitch_k) begin
            start = 1'b1; op = 4'd0; operand = 8'hFF;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, "_idle_after"}, 64'({busy, done, sh_oe, sh_db}), 64'd0);
        check({tag, "_hold"}, 64'({result, acc_out}), 64'({e.res, e.acc}));
    endtask

    initial begin
        nreset = 1'b0; start = 1'b0; op = 4'd0; operand = 8'h00; acc_in = 8'h00; cy_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              64'({busy, done, result, acc_out, cf, sf, zf, pf, sh_db, sh_enable, sh_right, sh_in, sh_oe}),
              64'd0);
        nreset = 1'b1;

        run_op("rlc81",  4'd0, 8'h81, 8'h55, 1'b0, 2, 0);
        run_op("rr01",   4'd3, 8'h01, 8'h55, 1'b0, 2, 0);
        run_op("sra80",  4'd5, 8'h80, 8'h00, 1'b1, 2, 0);
        run_op("sll00",  4'd6, 8'h00, 8'h00, 1'b0, 2, 0);
        run_op("rl_cy",  4'd2, 8'h4C, 8'h00, 1'b1, 2, 0);
        run_op("srl_b5", 4'd7, 8'hB5, 8'h00, 1'b1, 2, 2);
        run_op("rld",    4'd8, 8'h34, 8'h12, 1'b1, 5, 0);
        run_op("rrd",    4'd9, 8'h34, 8'h12, 1'b0, 5, 2);
        run_op("op12",   4'd12, 8'hA6, 8'h77, 1'b1, 2, 0);
        run_op("rrc_f0", 4'd1, 8'hF0, 8'h00, 1'b1, 2, 0);

        // Abort an RLD asynchronously during its third pass.
        @(negedge clk);
        op = 4'd8; operand = 8'h34; acc_in = 8'h12; cy_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_in_pass3", 64'({busy, sh_oe}), 64'h3);
        #2 nreset = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({busy, done, result, acc_out, cf, sf, zf, pf, sh_db, sh_enable, sh_right, sh_in, sh_oe}),
              64'd0);
        @(negedge clk);
        nreset = 1'b1;

        run_op("rlc_after_rst", 4'd0, 8'h81, 8'h00, 1'b0, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
